// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 3-sample majority vote per bit, feeding a show-ahead
// FIFO with valid/ready read side, framing-error and overrun pulses.
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          rxd,
   input  logic                          rx_ready,
   output logic                          rx_valid,
   output logic [7:0]                    rx_data,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_err,
   output logic                          overrun,
   output logic                          busy
);
   // state   | meaning
   // S_IDLE  | line idle, waiting for rxs low (that cycle is cnt=0)
   // S_START | start bit; majority 1 at centre means glitch
   // S_DATA  | 8 data bits, LSB first
   // S_STOP  | stop bit; leaves at the decision sample
   // S_BREAK | stop bit was low; wait for the line to return high
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   localparam int H  = CLKS_PER_BIT / 2;
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);

   state_t          state_q, state_d;
   logic [1:0]      sync_q;
   logic            rxs;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic [1:0]      smp_q, smp_d;
   logic            fe_q, fe_d, ov_q, ov_d;
   logic            maj, at_decide, at_end, push;

   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]     count_q, count_d;
   logic            pop, full, wr;

   assign rxs       = sync_q[1];
   assign at_decide = (cnt_q == CW'(H + 1));
   assign at_end    = (cnt_q == CW'(CLKS_PER_BIT - 1));
   assign maj       = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      smp_d   = smp_q;
      push    = 1'b0;
      fe_d    = 1'b0;
      if (cnt_q == CW'(H - 1)) smp_d[0] = rxs;
      if (cnt_q == CW'(H))     smp_d[1] = rxs;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rxs) begin
               state_d = S_START;
               cnt_d   = CW'(1);
            end
         end
         S_START: begin
            if (at_decide && maj) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (at_end) begin
               state_d = S_DATA;
               cnt_d   = '0;
               bit_d   = '0;
            end
         end
         S_DATA: begin
            if (at_decide) shift_d = {maj, shift_q[7:1]};
            if (at_end) begin
               cnt_d = '0;
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (at_decide) begin
               cnt_d = '0;
               if (maj) begin
                  push    = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  fe_d    = 1'b1;
                  state_d = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            cnt_d = '0;
            if (rxs) state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign pop  = rx_valid & rx_ready;
   assign full = (count_q == (AW+1)'(FIFO_DEPTH));
   assign wr   = push & (~full | pop);
   assign ov_d = push & full & ~pop;

   always_comb begin
      wptr_d  = wr  ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
      count_d = count_q;
      case ({wr, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q  <= 2'b11;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         smp_q   <= '0;
         fe_q    <= 1'b0;
         ov_q    <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         sync_q  <= {sync_q[0], rxd};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         smp_q   <= smp_d;
         fe_q    <= fe_d;
         ov_q    <= ov_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem_q[wptr_q] <= shift_q;
   end

   assign rx_valid   = (count_q != '0);
   assign rx_data    = rx_valid ? mem_q[rptr_q] : 8'h00;
   assign fifo_count = count_q;
   assign frame_err  = fe_q;
   assign overrun    = ov_q;
   assign busy       = (state_q != S_IDLE);
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Buffered UART receiver: the reader end of the 8N1 serial link driven by `uart_tx`. Samples the asynchronous `rxd` pin and majority-votes three samples around each bit centre. Delivers bytes through a 4-entry show-ahead FIFO with a valid/ready handshake. Flags framing errors and overruns, so the FPGA-side logic can drain received bytes at its own pace instead of catching one-cycle strobes.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per bit (100 MHz / 115200). Must be ≥ 8.
- `FIFO_DEPTH`, 4: receive FIFO entries. Must be a power of two.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rxd`  in  1  asynchronous serial input; idles high.
- `rx_ready`  in  1  consumer accepts the head byte when `rx_valid` is also high.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_data`  out  8  FIFO head byte (show-ahead); valid only while `rx_valid` is high.
- `fifo_count`  out  log2(FIFO_DEPTH)+1  number of bytes held.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: good byte dropped because the FIFO was full.
- `busy`  out  1  receiver FSM not in IDLE.

## Operation
- `rxd` passes through a 2-flop synchronizer (reset value 1) to form `rxs`. All FSM logic uses `rxs` only.
- H = CLKS_PER_BIT/2. A bit counter `cnt` runs 0..CLKS_PER_BIT-1.
- Three samples per bit are taken at cnt = H-1, H, H+1. The bit value is the majority of the three and is decided at cnt = H+1.
- FSM states:
  - IDLE: on `rxs`=0, clear `cnt` and go to START. The cycle in which `rxs` is first seen low is cnt=0.
  - START: at the decision, a majority of 1 is a glitch → IDLE. A majority of 0 → continue counting; at cnt = CLKS_PER_BIT-1, clear `cnt` and go to DATA with bit index 0.
  - DATA: 8 bits, LSB first, shifted into the shift register at each decision. At cnt = CLKS_PER_BIT-1 after bit 7 → STOP.
  - STOP: at the decision, majority 1 → push the byte. Majority 0 → pulse `frame_err`, discard the byte, go to BREAK. In both cases leave STOP at the decision cycle, without waiting for the end of the bit.
  - BREAK: wait for `rxs`=1, then → IDLE. This prevents a held-low line from producing phantom frames.
- FIFO:
  - Push and pop are both allowed in the same cycle.
  - Pop occurs when `rx_valid`&`rx_ready`.
  - Full, with a push and no pop: the byte is dropped and `overrun` pulses. Existing contents are untouched.
  - Full, with a simultaneous push and pop: both succeed, there is no overrun, and the count stays at FIFO_DEPTH.
  - Empty: `rx_ready` is ignored; pointers and count do not move.
- Read/write pointers wrap modulo FIFO_DEPTH. `fifo_count` is the source of full/empty.

## Timing
- Reset values:
  - `rx_valid`=0, `rx_data`=0, `fifo_count`=0, `frame_err`=0, `overrun`=0, `busy`=0.
  - FSM in IDLE, synchronizer = 1.
  - Pointers are cleared; FIFO contents are don't-care.
- Reset mid-frame abandons the frame immediately; no partial byte is pushed.
- Pin-to-`rxs` latency is 2 cycles.
- With T0 = the cycle in which `rxs` is first low:
  - Stop decision at T0 + 9·CLKS_PER_BIT + H + 1.
  - The push is registered on that edge: `rx_valid` and `fifo_count` update 1 cycle after the decision cycle.
- `frame_err` and `overrun` are asserted in the cycle after the stop decision, for exactly one cycle.
- `busy` is high from the cycle after T0 until the FSM re-enters IDLE.
- Pop: `rx_data` shows the next entry in the cycle after the handshake. `rx_valid` drops in that cycle if the FIFO became empty.
- Back-to-back frames: a start edge arriving H-1 or more cycles after the stop decision is detected. Stop bit length is therefore ≥ ~0.5 bit.

## Test plan
- CLKS_PER_BIT=16, rx_ready=1. Drive 0x61 then 0x62 via `uart_tx` → `rx_data` 0x61 then 0x62, each `rx_valid` for 1 cycle, at T0 + 153 ± 1. No `frame_err`.
- Low pulse of 3 cycles on idle `rxd` → FSM returns to IDLE; no push, no `frame_err`. `busy` is high for ≤ 9 cycles.
- Frame 0xA5 with the stop bit driven low, then the line held low for 40 cycles → one `frame_err` pulse; `fifo_count` stays 0; no further frames until `rxd` goes high; the next 0x3C is received correctly.
- rx_ready=0, send 0x01..0x05 → `fifo_count`=4 and one `overrun` pulse on 0x05. Then rx_ready=1 → pops 0x01, 0x02, 0x03, 0x04 on consecutive cycles, then `rx_valid`=0.
- FIFO full (0x11..0x14) with rx_ready asserted exactly in the push cycle of 0x15 → no overrun, count stays 4. Drain order is 0x12, 0x13, 0x14, 0x15.
- Assert `reset` for 1 cycle during data bit 4 of 0x7E → all outputs return to reset values, nothing is pushed, and the next full frame 0x81 is received correctly.
